// File: rtl/simon_tone_gen.sv
// ---------------------------------------------------------------------------
// simon_tone_gen
//
// Turns the 4-bit one-hot-ish `sound` request from the round animation and
// playback blocks into a square wave for the piezo speaker. Each game colour
// has its own fixed pitch, set by a half-period count in clk cycles.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous reset, active low (asserted at 0)
//   sound     in   [3:0] tone request, bit n requests tone n, 0 = silence
//   mute      in   forces silence while high (acts at the next edge)
//   speaker   out  square-wave speaker drive
//   active    out  high while a tone is being generated
//   tone_idx  out  [1:0] index of the tone playing, 0 when silent
//
// All outputs are registered. `sound` passes through one input register
// before it is decoded, so the speaker responds two edges after a change.
// ---------------------------------------------------------------------------
module simon_tone_gen #(
  parameter int unsigned HALF0 = 60241,
  parameter int unsigned HALF1 = 80645,
  parameter int unsigned HALF2 = 99206,
  parameter int unsigned HALF3 = 119617,
  parameter int unsigned CNT_W = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sound,
  input  logic       mute,
  output logic       speaker,
  output logic       active,
  output logic [1:0] tone_idx
);

  localparam logic [0:0] SILENT = 1'b0;
  localparam logic [0:0] PLAY   = 1'b1;

  // Counter reload values: one less than the half-period, because the
  // counter spends one cycle at zero before the toggle.
  localparam logic [CNT_W-1:0] RELOAD0 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] RELOAD1 = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] RELOAD2 = CNT_W'(HALF2 - 1);
  localparam logic [CNT_W-1:0] RELOAD3 = CNT_W'(HALF3 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       sound_q;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur;

  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       cur_nxt;
  logic             speaker_nxt;
  logic             active_nxt;
  logic [1:0]       tone_idx_nxt;

  logic             req;
  logic [1:0]       idx;

  // Reload value for a given tone index.
  function automatic logic [CNT_W-1:0] reload_for(input logic [1:0] sel);
    logic [CNT_W-1:0] r;
    case (sel)
      2'd0:    r = RELOAD0;
      2'd1:    r = RELOAD1;
      2'd2:    r = RELOAD2;
      default: r = RELOAD3;
    endcase
    return r;
  endfunction

  // Request decode. Lowest set bit wins when several colours are requested
  // at once; mute is deliberately not registered so it bites on the next edge.
  always_comb begin
    req = (|sound_q) & ~mute;
    idx = 2'd0;
    if (sound_q[0])      idx = 2'd0;
    else if (sound_q[1]) idx = 2'd1;
    else if (sound_q[2]) idx = 2'd2;
    else if (sound_q[3]) idx = 2'd3;
  end

  // Next-state logic. Starting a tone (from silence or by switching colour)
  // always begins with the speaker high and a full half-period; there is no
  // attempt to keep phase across a colour change. A re-request of the same
  // colour with no silent gap just keeps the waveform running.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_nxt      = cur;
    speaker_nxt  = speaker;
    active_nxt   = active;
    tone_idx_nxt = tone_idx;

    case (state)
      SILENT: begin
        if (req) begin
          state_nxt    = PLAY;
          cur_nxt      = idx;
          speaker_nxt  = 1'b1;
          active_nxt   = 1'b1;
          tone_idx_nxt = idx;
          cnt_nxt      = reload_for(idx);
        end else begin
          cnt_nxt      = '0;
          speaker_nxt  = 1'b0;
          active_nxt   = 1'b0;
          tone_idx_nxt = 2'd0;
        end
      end

      PLAY: begin
        if (!req) begin
          state_nxt    = SILENT;
          speaker_nxt  = 1'b0;
          active_nxt   = 1'b0;
          tone_idx_nxt = 2'd0;
          cnt_nxt      = '0;
        end else if (idx != cur) begin
          cur_nxt      = idx;
          speaker_nxt  = 1'b1;
          active_nxt   = 1'b1;
          tone_idx_nxt = idx;
          cnt_nxt      = reload_for(idx);
        end else if (cnt != '0) begin
          cnt_nxt      = cnt - CNT_ONE;
        end else begin
          speaker_nxt  = ~speaker;
          cnt_nxt      = reload_for(cur);
        end
      end

      default: begin
        state_nxt    = SILENT;
        speaker_nxt  = 1'b0;
        active_nxt   = 1'b0;
        tone_idx_nxt = 2'd0;
        cnt_nxt      = '0;
        cur_nxt      = 2'd0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so the speaker is cut
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sound_q  <= 4'd0;
      state    <= SILENT;
      cnt      <= '0;
      cur      <= 2'd0;
      speaker  <= 1'b0;
      active   <= 1'b0;
      tone_idx <= 2'd0;
    end else begin
      sound_q  <= sound;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur      <= cur_nxt;
      speaker  <= speaker_nxt;
      active   <= active_nxt;
      tone_idx <= tone_idx_nxt;
    end
  end

endmodule
